mul_seq: RTL and testbench
==========================

# mul_seq

Sequential unsigned fixed-point multiplier, U(W,F) × U(W,F) → U(W,F), with valid/ready handshakes on input and output. It computes with one radix-2 shift-add step per clock instead of a single wide combinational multiply. It saturates on overflow instead of silently dropping high bits, and optionally rounds to nearest. It is the low-area multiplier for the synth datapath (envelope scaling, gain stages), where a sample-rate clock leaves many cycles per result.

## Interface
- `TOTAL_BITS`, 16, operand and result width W; must be ≥ 2.
- `FRACTIONAL_BITS`, 8, fractional bits F; must satisfy 0 ≤ F < W.
- `clk`  input  1  clock; all state changes on its rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  operands `in1`/`in2` are valid.
- `in_ready`  output  1  block can accept operands this cycle.
- `in1`  input  W  multiplicand, U(W−F,F).
- `in2`  input  W  multiplier, U(W−F,F).
- `out_valid`  output  1  `out` and `overflow` are valid.
- `out_ready`  input  1  consumer takes the result this cycle.
- `out`  output  W  product, U(W−F,F), saturated.
- `overflow`  output  1  high with `out_valid` when the result was saturated.

## Operation
- States: IDLE, BUSY, DONE.
- **IDLE:** `in_ready`=1.
  - On `in_valid`: latch `in1` into the multiplicand register (2W wide, zero-extended).
  - Latch `in2` into the multiplier shift register.
  - Clear the 2W-bit accumulator, set the bit counter to W, go to BUSY.
- **BUSY:** one step per cycle.
  - If the multiplier LSB is 1, add the multiplicand to the accumulator.
  - Shift the multiplicand left 1, shift the multiplier right 1, decrement the counter.
  - On the step that brings the counter to 0, register the final result and go to DONE.
- **Result formation:** P is the exact 2W-bit product.
  - R = (P + B) >> F, where B is the rounding bias (see Configuration).
  - If R > 2^W−1: `out` = all ones, `overflow`=1.
  - Otherwise: `out` = R[W−1:0], `overflow`=0.
  - R is computed at 2W+1 bits so that adding the bias cannot wrap.
- **DONE:** `out_valid`=1; `out` and `overflow` are held stable until `out_ready`=1.
  - `out_ready`=1 and `in_valid`=0: go to IDLE.
  - `out_ready`=1 and `in_valid`=1: accept the new operands in the same cycle (`in_ready`=1) and go directly to BUSY.
- `in_ready` = (state==IDLE) || (state==DONE && `out_ready`). It is never high in BUSY.
- Operand changes while BUSY are ignored.
- `in_valid` may be held high across results. Each accept edge consumes exactly one operand pair.
- **Reset**, asynchronous and at any time including mid-BUSY:
  - State → IDLE; `in_ready` is 1 after reset deasserts.
  - `out_valid`=0, `out`=0, `overflow`=0; accumulator, counter and operand registers cleared.
  - An in-flight operation is discarded with no output.

## Timing
- Accept edge = rising edge with `in_valid` && `in_ready`.
- Latency: `out_valid` rises exactly W clocks after the accept edge (W=16: 16 cycles).
- Back-to-back throughput: one result per W+1 cycles when the consumer holds `out_ready`=1 and the producer holds `in_valid`=1.
- All outputs are registered. There is no combinational path from inputs to `out`, `overflow` or `out_valid`.
- `in_ready` depends combinationally on `out_ready`, and only in DONE.

## Configuration
- Macro: `MUL_SEQ_ROUND_EN`.
- Defined: B = 2^(F−1) when F > 0, B = 0 when F = 0. The result is round-half-up to nearest, and rounding can trigger saturation.
- Undefined: B = 0. The result is truncated toward zero.
- Latency and handshake behaviour are identical in both builds.

## Test plan
All scenarios use W=16, F=8.
- **Basic product:** `in1`=0x0200, `in2`=0x0300 (2.0×3.0), `out_ready`=1 → after exactly 16 cycles, `out_valid`=1, `out`=0x0600, `overflow`=0.
- **Saturation:** `in1`=0x1000, `in2`=0x1000 (16.0×16.0) → `out`=0xFFFF, `overflow`=1. Also `in1`=0xFFFF, `in2`=0x0100 → `out`=0xFFFF, `overflow`=0.
- **Rounding:** `in1`=0x0001, `in2`=0x0080.
  - With `MUL_SEQ_ROUND_EN`: `out`=0x0001.
  - Without it: `out`=0x0000.
  - `overflow`=0 in both builds.
- **Backpressure:** hold `out_ready`=0 for 10 cycles after `out_valid` → `out` and `overflow` stay stable and `in_ready`=0 throughout. Raise `out_ready` with `in_valid`=1 and a new pair → same-cycle accept; next `out_valid` comes 16 cycles later.
- **Streaming:** 20 random operand pairs with `in_valid` and `out_ready` held at 1 → exactly 20 results in order, each matching the reference model (saturated product, rounding per build), with a period of 17 cycles.
- **Reset mid-operation:** assert `reset_n`=0 for 1 cycle, 5 cycles into BUSY → outputs immediately 0 and no result emitted. `in_ready`=1 after release; the next accepted pair produces a correct result 16 cycles later.

Source files
------------

// File: rtl/mul_seq.sv
// mul_seq: sequential unsigned fixed-point multiplier, U(W,F) x U(W,F) -> U(W,F).
// One radix-2 shift-add step per clock, W steps per product. Results above the
// representable range saturate to all ones and raise overflow.
//
// Build option: define MUL_SEQ_ROUND_EN for round-half-up to nearest; when it
// is undefined the result is truncated toward zero. Timing is the same in both.
//
// Ports:
//   clk        clock, rising edge
//   reset_n    asynchronous active-low reset
//   in_valid   operand pair on in1/in2 is valid
//   in_ready   operands are accepted this cycle (IDLE, or DONE with out_ready)
//   in1, in2   multiplicand / multiplier, U(W-F,F)
//   out_valid  out/overflow hold a result
//   out_ready  consumer takes the result this cycle
//   out        saturated product, U(W-F,F)
//   overflow   result was saturated
//
// state | meaning
// IDLE  | waiting for operands
// BUSY  | shift-add steps in progress, counter counts W..1
// DONE  | result held until out_ready
module mul_seq #(
  parameter int TOTAL_BITS      = 16,
  parameter int FRACTIONAL_BITS = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [TOTAL_BITS-1:0] in1,
  input  logic [TOTAL_BITS-1:0] in2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TOTAL_BITS-1:0] out,
  output logic                  overflow
);

  localparam int W  = TOTAL_BITS;
  localparam int F  = FRACTIONAL_BITS;
  localparam int CW = $clog2(W + 1);

`ifdef MUL_SEQ_ROUND_EN
  // Half an output LSB; the inner conditional keeps the shift amount legal when F=0.
  localparam logic [2*W:0] BIAS = (F > 0) ? ((2*W+1)'(1) << ((F > 0) ? F - 1 : 0)) : '0;
`else
  localparam logic [2*W:0] BIAS = '0;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [2*W-1:0]  r_mcand;
  logic [2*W-1:0]  r_acc;
  logic [W-1:0]    r_mplier;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_out;
  logic            r_overflow;

  logic            w_accept;
  logic            w_last;
  logic [2*W-1:0]  w_acc_next;
  logic [2*W:0]    w_biased;
  logic [2*W:0]    w_scaled;
  logic            w_sat;

  assign w_accept   = in_valid && in_ready;
  assign w_last     = (r_state == BUSY) && (r_cnt == CW'(1));
  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  // Extra top bit so adding the bias to a full-scale product cannot wrap.
  assign w_biased   = {1'b0, w_acc_next} + BIAS;
  assign w_scaled   = w_biased >> F;
  assign w_sat      = |w_scaled[2*W:W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = BUSY;
      end
      BUSY: begin
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        // Consumer draining the result frees the slot in the same cycle.
        in_ready = out_ready;
        if (out_ready) w_state_next = in_valid ? BUSY : IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mcand    <= '0;
      r_acc      <= '0;
      r_mplier   <= '0;
      r_cnt      <= '0;
      r_out      <= '0;
      r_overflow <= 1'b0;
    end else if (w_accept) begin
      r_mcand  <= {{W{1'b0}}, in1};
      r_mplier <= in2;
      r_acc    <= '0;
      r_cnt    <= CW'(W);
    end else if (r_state == BUSY) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CW'(1);
      if (w_last) begin
        r_out      <= w_sat ? '1 : w_scaled[W-1:0];
        r_overflow <= w_sat;
      end
    end
  end

  assign out_valid = (r_state == DONE);
  assign out       = r_out;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_mul_seq.sv
module tb_mul_seq;

  localparam int W = 16;
`ifdef MUL_SEQ_ROUND_EN
  localparam logic RND = 1'b1;
`else
  localparam logic RND = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in1 = '0;
  logic [W-1:0]  in2 = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out;
  logic          overflow;

  mul_seq #(.TOTAL_BITS(16), .FRACTIONAL_BITS(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in1(in1), .in2(in2),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_results = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // expected result attached to the operands currently driven
  logic [W-1:0] cur_eo = '0;
  logic         cur_ev = 1'b0;

  logic [W:0] exp_q[$];
  int         acc_q[$];
  int         rise_cyc[$];
  logic       prev_ov = 1'b0;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s actual=event required=none (t=%0t)", nm, $time);
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [32:0] p;
    p = {1'b0, 32'(a) * 32'(b)};
    if (RND) p = p + 33'h80;
    p = p >> 8;
    if (p > 33'hFFFF) return {16'hFFFF, 1'b1};
    return {p[15:0], 1'b0};
  endfunction

  // Monitor / scoreboard: handshakes are resolved at the negedge before the edge that takes them.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      acc_q.delete();
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        rise_cyc.push_back(cyc);
        if (acc_q.size() == 0) fail("out_valid_without_accept");
        else chk("latency", cyc - acc_q.pop_front(), 16);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail("unexpected_result");
        else begin
          logic [W:0] e;
          e = exp_q.pop_front();
          chk("out", int'(out), int'(e[W:1]));
          chk("overflow", int'(overflow), int'(e[0]));
          n_results++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({cur_eo, cur_ev});
        acc_q.push_back(cyc + 1);
      end
      prev_ov = out_valid;
    end
  end

  // Call at posedge+#1; returns at posedge+#1 right after the accept edge, in_valid still high.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] eo, input logic ev);
    int n;
    in1 = a; in2 = b; cur_eo = eo; cur_ev = ev; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", int'(in_ready), 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input int max);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] eo;
    logic         ev;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_n, base_r, n;
    logic [W-1:0] a, b;
    logic [W:0] m;

    vecs[0] = '{16'h0200, 16'h0300, 16'h0600, 1'b0};
    vecs[1] = '{16'h1000, 16'h1000, 16'hFFFF, 1'b1};
    vecs[2] = '{16'hFFFF, 16'h0100, 16'hFFFF, 1'b0};
    vecs[3] = '{16'h0001, 16'h0080, RND ? 16'h0001 : 16'h0000, 1'b0};
    vecs[4] = '{16'h0180, 16'h0180, 16'h0240, 1'b0};
    vecs[5] = '{16'h0000, 16'hFFFF, 16'h0000, 1'b0};
    vecs[6] = '{16'h0003, 16'h0081, RND ? 16'h0002 : 16'h0001, 1'b0};
    vecs[7] = '{16'h0FFF, 16'h1001, 16'hFFFF, RND};
    vecs[8] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1};
    vecs[9] = '{16'h0100, 16'h0001, 16'h0001, 1'b0};

    // reset state
    #12;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out", int'(out), 0);
    chk("rst_overflow", int'(overflow), 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #1 chk("rst_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;

    // table-driven vectors, one at a time
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].eo, vecs[i].ev);
      in_valid = 1'b0;
      wait_drain(40);
    end

    // backpressure: 2.5 * 2.0 held for 10 cycles, then same-cycle reaccept
    out_ready = 1'b0;
    send(16'h0280, 16'h0200, 16'h0500, 1'b0);
    in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid", int'(out_valid), 1);
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_out", int'(out), 16'h0500);
      chk("bp_hold_ovf", int'(overflow), 0);
      chk("bp_in_ready_low", int'(in_ready), 0);
      chk("bp_valid_held", int'(out_valid), 1);
      @(negedge clk);
    end
    @(posedge clk); #1;
    in1 = 16'h0100; in2 = 16'h0340; cur_eo = 16'h0340; cur_ev = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1 chk("bp_same_cycle_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_drain(40);

    // streaming: 20 random pairs, in_valid and out_ready held high
    base_n = n_results;
    base_r = rise_cyc.size();
    for (int i = 0; i < 20; i++) begin
      a = W'($urandom);
      b = (i % 2 == 0) ? W'($urandom_range(0, 16'h01FF)) : W'($urandom);
      m = model(a, b);
      send(a, b, m[W:1], m[0]);
    end
    in_valid = 1'b0;
    wait_drain(60);
    chk("stream_count", n_results - base_n, 20);
    for (int i = base_r + 1; i < base_r + 20 && i < rise_cyc.size(); i++)
      chk("stream_period", rise_cyc[i] - rise_cyc[i-1], 17);

    // reset five cycles into BUSY
    m = model(16'h1234, 16'h0200);
    send(16'h1234, 16'h0200, m[W:1], m[0]);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out", int'(out), 0);
    chk("midrst_overflow", int'(overflow), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    #1 chk("midrst_in_ready", int'(in_ready), 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("midrst_no_output", int'(out_valid), 0);
    end
    @(posedge clk); #1;
    m = model(16'h0340, 16'h0180);
    send(16'h0340, 16'h0180, m[W:1], m[0]);
    in_valid = 1'b0;
    wait_drain(40);
    chk("midrst_after_result", int'(m[W:1]), 16'h04E0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
